// File: rtl/simd_result_writer_if.sv
// Result-memory write port: valid/ready, one lane per handshake.
// Master issues writes, slave (memory) accepts with mem_ready.
interface simd_result_writer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/simd_result_writer.sv
// Captures a SIMD result vector on write_back and streams it lane by lane
// into result memory, tracking a running write pointer across batches.
module simd_result_writer #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_start,
  input  logic [LANES*DATA_W-1:0] lanes_in,
  input  logic                    ptr_load,
  input  logic [ADDR_W-1:0]       base_addr,
  simd_result_writer_if.master    wr,
  output logic                    busy,
  output logic                    wb_done,
  output logic [15:0]             batch_cnt,
  output logic                    err_overrun,
  output logic                    wrapped
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

  logic [1:0]              state;
  logic [ADDR_W-1:0]       ptr;
  logic [IDX_W-1:0]        lane_idx;
  logic [LANES*DATA_W-1:0] lane_buf;

  logic in_idle;
  logic in_write;
  logic in_done;

  assign in_idle  = (state == IDLE);
  assign in_write = (state == WRITE);
  assign in_done  = (state == DONE);

  // All port outputs derive from registers only; mem_ready never
  // reaches them combinationally.
  assign wr.mem_we    = in_write;
  assign wr.mem_addr  = ptr;
  assign wr.mem_wdata = lane_buf[lane_idx*DATA_W +: DATA_W];

  assign busy    = !in_idle;
  assign wb_done = in_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      lane_idx    <= '0;
      lane_buf    <= '0;
      batch_cnt   <= '0;
      err_overrun <= 1'b0;
      wrapped     <= 1'b0;
    end else begin
      if (wb_start && !in_idle)
        err_overrun <= 1'b1;

      unique case (1'b1)
        in_idle: begin
          if (ptr_load)
            ptr <= base_addr;
          if (wb_start) begin
            lane_buf <= lanes_in;
            lane_idx <= '0;
            state    <= WRITE;
          end
        end
        in_write: begin
          if (wr.mem_ready) begin
            ptr <= ptr + 1'b1;
            if (&ptr)
              wrapped <= 1'b1;
            if (lane_idx == LAST) begin
              lane_idx <= '0;
              state    <= DONE;
            end else begin
              lane_idx <= lane_idx + 1'b1;
            end
          end
        end
        in_done: begin
          if (batch_cnt != 16'hFFFF)
            batch_cnt <= batch_cnt + 16'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_result_writer.sv
// Scoreboard bench for simd_result_writer: directed batches,
// stalls, overrun, pointer wrap, mid-batch reset, load+start.
module tb_simd_result_writer;

  logic        clk;
  logic        rst;
  logic        wb_start;
  logic [31:0] lanes_in;
  logic        ptr_load;
  logic [15:0] base_addr;
  logic        busy;
  logic        wb_done;
  logic [15:0] batch_cnt;
  logic        err_overrun;
  logic        wrapped;

  simd_result_writer_if #(.DATA_W(8), .ADDR_W(16)) wr_bus ();

  simd_result_writer #(.LANES(4), .DATA_W(8), .ADDR_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_start    (wb_start),
    .lanes_in    (lanes_in),
    .ptr_load    (ptr_load),
    .base_addr   (base_addr),
    .wr          (wr_bus),
    .busy        (busy),
    .wb_done     (wb_done),
    .batch_cnt   (batch_cnt),
    .err_overrun (err_overrun),
    .wrapped     (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [23:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted write.
  logic        stall_q = 1'b0;
  logic [15:0] stall_addr;
  logic [7:0]  stall_data;

  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_we", {31'd0, wr_bus.mem_we}, 32'd1);
        chk("stall_addr", {16'd0, wr_bus.mem_addr}, {16'd0, stall_addr});
        chk("stall_data", {24'd0, wr_bus.mem_wdata}, {24'd0, stall_data});
      end
      if (wr_bus.mem_we && wr_bus.mem_ready) begin
        if (exp_q.size() == 0) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL unexpected_write: got addr %h data %h expected none",
                   wr_bus.mem_addr, wr_bus.mem_wdata);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", {16'd0, wr_bus.mem_addr}, {16'd0, e[23:8]});
          chk("wr_data", {24'd0, wr_bus.mem_wdata}, {24'd0, e[7:0]});
        end
      end
      stall_q    = wr_bus.mem_we && !wr_bus.mem_ready;
      stall_addr = wr_bus.mem_addr;
      stall_data = wr_bus.mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_batch(input logic [31:0] l, input logic [15:0] a,
                              input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] ad;
      ad = a + 16'(i);
      exp_q.push_back({ad, l[i*8 +: 8]});
    end
  endtask

  task automatic pulse(input logic [31:0] l);
    tick();
    wb_start = 1'b1;
    lanes_in = l;
    tick();
    wb_start = 1'b0;
    lanes_in = 32'hDEADBEEF;
  endtask

  task automatic load_ptr(input logic [15:0] a);
    tick();
    ptr_load  = 1'b1;
    base_addr = a;
    tick();
    ptr_load  = 1'b0;
    base_addr = 16'h5A5A;
  endtask

  task automatic wait_done(input string name, input int c0, output int c);
    c = c0;
    while (!wb_done && c < c0 + 60) begin
      tick();
      c++;
    end
    if (!wb_done)
      chk({name, "_timeout"}, {31'd0, wb_done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    rst       = 1'b1;
    wb_start  = 1'b0;
    lanes_in  = '0;
    ptr_load  = 1'b0;
    base_addr = '0;
    wr_bus.mem_ready = 1'b1;
    repeat (3) tick();
    chk("rst_we", {31'd0, wr_bus.mem_we}, 32'd0);
    chk("rst_addr", {16'd0, wr_bus.mem_addr}, 32'd0);
    chk("rst_wdata", {24'd0, wr_bus.mem_wdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, wb_done}, 32'd0);
    chk("rst_cnt", {16'd0, batch_cnt}, 32'd0);
    chk("rst_ovr", {31'd0, err_overrun}, 32'd0);
    chk("rst_wrap", {31'd0, wrapped}, 32'd0);
    rst = 1'b0;

    // 1: basic batch at 0x0010
    load_ptr(16'h0010);
    expect_batch(32'h44332211, 16'h0010, 4);
    pulse(32'h44332211);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_done("t1", 1, c);
    chk("t1_latency", c, 5);
    tick();
    chk("t1_cnt", {16'd0, batch_cnt}, 32'd1);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // 2: stall lane 2 for three cycles
    expect_batch(32'h44332211, 16'h0014, 4);
    pulse(32'h44332211);
    tick();
    tick();
    wr_bus.mem_ready = 1'b0;
    repeat (3) tick();
    wr_bus.mem_ready = 1'b1;
    wait_done("t2", 6, c);
    chk("t2_latency", c, 8);
    tick();
    chk("t2_cnt", {16'd0, batch_cnt}, 32'd2);
    chk("t2_ovr", {31'd0, err_overrun}, 32'd0);

    // 3: overrun during WRITE
    expect_batch(32'hA3A2A1A0, 16'h0018, 4);
    pulse(32'hA3A2A1A0);
    tick();
    wb_start = 1'b1;
    lanes_in = 32'h55555555;
    tick();
    wb_start = 1'b0;
    wait_done("t3", 3, c);
    chk("t3_latency", c, 5);
    tick();
    chk("t3_ovr", {31'd0, err_overrun}, 32'd1);
    chk("t3_cnt", {16'd0, batch_cnt}, 32'd3);
    repeat (8) tick();
    chk("t3_qempty", exp_q.size(), 0);

    // 4: pointer wrap
    load_ptr(16'hFFFE);
    chk("t4_wrap_pre", {31'd0, wrapped}, 32'd0);
    expect_batch(32'h0D0C0B0A, 16'hFFFE, 4);
    pulse(32'h0D0C0B0A);
    wait_done("t4", 1, c);
    tick();
    chk("t4_wrap", {31'd0, wrapped}, 32'd1);
    chk("t4_cnt", {16'd0, batch_cnt}, 32'd4);

    // 5: reset after lane 1 accepted
    expect_batch(32'h78563412, 16'h0002, 2);
    pulse(32'h78563412);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t5_we", {31'd0, wr_bus.mem_we}, 32'd0);
    chk("t5_addr", {16'd0, wr_bus.mem_addr}, 32'd0);
    chk("t5_wdata", {24'd0, wr_bus.mem_wdata}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_cnt", {16'd0, batch_cnt}, 32'd0);
    chk("t5_ovr", {31'd0, err_overrun}, 32'd0);
    chk("t5_wrap", {31'd0, wrapped}, 32'd0);
    chk("t5_qempty", exp_q.size(), 0);
    tick();
    rst = 1'b0;
    expect_batch(32'hC4C3C2C1, 16'h0000, 4);
    pulse(32'hC4C3C2C1);
    wait_done("t5b", 1, c);
    chk("t5b_latency", c, 5);
    tick();
    chk("t5b_cnt", {16'd0, batch_cnt}, 32'd1);

    // 6: ptr_load and wb_start together
    expect_batch(32'h87654321, 16'h0100, 4);
    tick();
    ptr_load  = 1'b1;
    base_addr = 16'h0100;
    wb_start  = 1'b1;
    lanes_in  = 32'h87654321;
    tick();
    ptr_load  = 1'b0;
    wb_start  = 1'b0;
    lanes_in  = 32'hDEADBEEF;
    wait_done("t6", 1, c);
    tick();
    chk("t6_cnt", {16'd0, batch_cnt}, 32'd2);
    repeat (4) tick();
    chk("end_qempty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
